// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: FSM state encoding, flush
// vector layout and default boot/interrupt addresses.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_VEC   = 2'd3
   } state_e;

   localparam int FL_FD = 0;
   localparam int FL_DE = 1;
   localparam int FL_EX = 2;
   localparam int FL_W  = 3;

   localparam int          DEF_ADDR_W       = 32;
   localparam int unsigned DEF_RESET_PC     = 32;
   localparam int unsigned DEF_INT_VEC      = 16;
   localparam int unsigned DEF_DRAIN_CYCLES = 3;

   // A redirect resolved n stages deep kills the n younger pipeline registers.
   function automatic logic [FL_W-1:0] flush_upto(input int n);
      return FL_W'((1 << n) - 1);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control bus between pipeline hazard/redirect logic, the PC register and the sequencer.
interface pc_sequencer_if #(parameter int ADDR_W = 32);

   logic [ADDR_W-1:0] pc_q;
   logic              instr_len;
   logic              stall;
   logic              jump;
   logic [ADDR_W-1:0] jump_target;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic              ret_valid;
   logic [ADDR_W-1:0] ret_target;
   logic              int_req;
   logic              pc_we;
   logic [ADDR_W-1:0] pc_next;
   logic              flush_fd;
   logic              flush_de;
   logic              flush_ex;
   logic              int_ack;
   logic [ADDR_W-1:0] saved_pc;

   modport slave (
      input  pc_q, instr_len, stall, jump, jump_target, branch_taken, branch_target,
             ret_valid, ret_target, int_req,
      output pc_we, pc_next, flush_fd, flush_de, flush_ex, int_ack, saved_pc
   );

   modport master (
      output pc_q, instr_len, stall, jump, jump_target, branch_taken, branch_target,
             ret_valid, ret_target, int_req,
      input  pc_we, pc_next, flush_fd, flush_de, flush_ex, int_ack, saved_pc
   );

endinterface

// File: rtl/pc_sequencer_pc_next_mux.sv
// Combinational redirect priority (ret > branch > jump) and sequential PC increment.
module pc_next_mux
   import pc_sequencer_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0] pc_q,
   input  logic              instr_len,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              ret_valid,
   input  logic [ADDR_W-1:0] ret_target,
   output logic              redir,
   output logic [ADDR_W-1:0] redir_target,
   output logic [FL_W-1:0]   redir_flush,
   output logic [ADDR_W-1:0] seq_pc
);

   always_comb begin
      redir        = 1'b0;
      redir_target = pc_q;
      redir_flush  = '0;
      if (ret_valid) begin
         redir        = 1'b1;
         redir_target = ret_target;
         redir_flush  = flush_upto(3);
      end else if (branch_taken) begin
         redir        = 1'b1;
         redir_target = branch_target;
         redir_flush  = flush_upto(2);
      end else if (jump) begin
         redir        = 1'b1;
         redir_target = jump_target;
         redir_flush  = flush_upto(1);
      end
   end

   // Wraps naturally at 2^ADDR_W.
   assign seq_pc = pc_q + ADDR_W'(instr_len) + ADDR_W'(1);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot load, redirect/stall handling, and interrupt entry
// (drain older instructions, then load the vector and report the return PC).
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int          ADDR_W       = DEF_ADDR_W,
   parameter int unsigned RESET_PC     = DEF_RESET_PC,
   parameter int unsigned INT_VEC      = DEF_INT_VEC,
   parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
   input  logic          clk,
   input  logic          rst,
   pc_sequencer_if.slave bus
);

   localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

   state_e            state_q, state_d;
   logic              pending_q, pending_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] saved_q, saved_d;

   logic              redir;
   logic [ADDR_W-1:0] redir_target, seq_pc;
   logic [FL_W-1:0]   redir_flush;

   logic              we, ack;
   logic [ADDR_W-1:0] nxt;
   logic [FL_W-1:0]   fl;

   pc_next_mux #(.ADDR_W(ADDR_W)) u_mux (
      .pc_q          (bus.pc_q),
      .instr_len     (bus.instr_len),
      .jump          (bus.jump),
      .jump_target   (bus.jump_target),
      .branch_taken  (bus.branch_taken),
      .branch_target (bus.branch_target),
      .ret_valid     (bus.ret_valid),
      .ret_target    (bus.ret_target),
      .redir         (redir),
      .redir_target  (redir_target),
      .redir_flush   (redir_flush),
      .seq_pc        (seq_pc)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_BOOT;
         pending_q <= 1'b0;
         cnt_q     <= '0;
         saved_q   <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         saved_q   <= saved_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q | bus.int_req;
      cnt_d     = cnt_q;
      saved_d   = saved_q;
      we        = 1'b0;
      nxt       = bus.pc_q;
      fl        = '0;
      ack       = 1'b0;
      unique case (state_q)
         S_BOOT: begin
            pending_d = pending_q;
            we        = 1'b1;
            nxt       = ADDR_W'(RESET_PC);
            fl        = flush_upto(3);
            state_d   = S_RUN;
         end
         S_RUN: begin
            if (redir) begin
               we  = 1'b1;
               nxt = redir_target;
               fl  = redir_flush;
            end else if (bus.stall) begin
               we = 1'b0;
            end else if (pending_q || bus.int_req) begin
               // A same-cycle request is accepted immediately.
               fl[FL_FD] = 1'b1;
               saved_d   = bus.pc_q;
               cnt_d     = CNT_W'(DRAIN_CYCLES);
               state_d   = S_DRAIN;
            end else begin
               we  = 1'b1;
               nxt = seq_pc;
            end
         end
         S_DRAIN: begin
            fl[FL_FD] = 1'b1;
            // Older instructions may still redirect: they define the return point.
            if (redir) begin
               saved_d = redir_target;
               fl      = fl | redir_flush;
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_VEC;
         end
         S_VEC: begin
            we        = 1'b1;
            nxt       = ADDR_W'(INT_VEC);
            ack       = 1'b1;
            fl[FL_FD] = 1'b1;
            pending_d = bus.int_req;
            state_d   = S_RUN;
         end
         default: state_d = S_BOOT;
      endcase
   end

   assign bus.pc_we    = rst & we;
   assign bus.pc_next  = rst ? nxt : '0;
   assign bus.flush_fd = rst & fl[FL_FD];
   assign bus.flush_de = rst & fl[FL_DE];
   assign bus.flush_ex = rst & fl[FL_EX];
   assign bus.int_ack  = rst & ack;
   assign bus.saved_pc = rst ? saved_q : '0;

endmodule
